mpa_mips_muldiv: RTL and testbench
==================================

MPA_MIPS_MULDIV -- requirements
Module: mpa_mips_muldiv

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 HW_RSTn  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  begin operation; sampled on a rising edge.
REQ-005 OP  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 RS  input  32  operand A (multiplicand/dividend), taken from register-file read port 0.
REQ-007 RT  input  32  operand B (multiplier/divisor), taken from register-file read port 1.
REQ-008 HI_WE  input  1  MTHI write strobe.
REQ-009 LO_WE  input  1  MTLO write strobe.
REQ-010 WDATA  input  32  MTHI/MTLO data.
REQ-011 BUSY  output  1  operation in progress.
REQ-012 DONE  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 HI  output  32  HI register (product[63:32] / remainder); feeds the writeback mux for MFHI.
REQ-014 LO  output  32  LO register (product[31:0] / quotient); feeds the writeback mux for MFLO.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 When START=1 at an edge in IDLE, the block SHALL latch OP, RS and RT, clear a 6-bit iteration counter, set BUSY=1 and enter RUN.
REQ-017 The engine SHALL be radix-2 shift-add for multiply and restoring for divide, operating on operand magnitudes with one iteration per edge in RUN.
REQ-018 Signed operations SHALL take magnitudes at latch time and apply sign correction on the final write.
REQ-019 For a START at edge k, HI/LO SHALL update at edge k+32; at that same edge the FSM SHALL return to IDLE, BUSY SHALL fall, and DONE SHALL be high for exactly the following cycle.
REQ-020 Latency SHALL be 32 cycles for all OP values and all operand values; there is no early termination.
REQ-021 MULT/MULTU SHALL produce {HI,LO} equal to the full 64-bit signed/unsigned product.
REQ-022 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend; DIVU SHALL be pure unsigned division.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 Divide by zero SHALL raise no exception.
REQ-025 On divide by zero, DIVU SHALL give HI=RS and LO=0xFFFFFFFF.
REQ-026 On divide by zero, DIV SHALL give HI=RS, with LO=0x00000001 if RS[31]=1 and LO=0xFFFFFFFF otherwise.
REQ-027 START SHALL be ignored while in RUN, with no effect on the operation in progress.
REQ-028 HI_WE/LO_WE in IDLE SHALL write WDATA to HI/LO at that edge; in RUN they SHALL be ignored.
REQ-029 If START and HI_WE/LO_WE are both asserted in IDLE, the MTHI/MTLO write SHALL occur and the operation SHALL start; the result SHALL later overwrite HI and LO.
REQ-030 START asserted in the DONE cycle (state IDLE) SHALL be accepted, allowing back-to-back operations with no gap cycle.
REQ-031 Operands SHALL be consumed only at the START edge; later changes on RS/RT SHALL have no effect.
REQ-032 Outside of REQ-019 and REQ-028, HI/LO SHALL hold their values.

Reset
REQ-033 When HW_RSTn=0 at an edge, the block SHALL enter IDLE with BUSY=0, DONE=0, HI=0, LO=0 and counter=0.
REQ-034 Reset asserted mid-RUN SHALL abort the operation with no partial result visible.
REQ-035 Reset SHALL take priority over START, HI_WE and LO_WE.
REQ-036 After reset, no DONE pulse SHALL occur until a new START.

Verification
REQ-037 MULTU RS=0xFFFFFFFF, RT=0xFFFFFFFF -> DONE 32 cycles after START; HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 MULT RS=0xFFFFFFFD (-3), RT=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-039 DIV RS=-7, RT=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU RS=100, RT=0 -> HI=100, LO=0xFFFFFFFF.
REQ-040 START DIV at edge k, second START at k+5, HW_RSTn low at k+10 -> the second START is ignored, BUSY=0 and HI=LO=0 after k+10, and no DONE pulse occurs.
REQ-041 MTLO 0x1234 in IDLE -> LO=0x1234 next cycle; LO_WE during RUN -> LO is unchanged until the result is written.
REQ-042 START in the DONE cycle of a MULTU 3×5 with a DIVU 9/2 -> first result HI=0, LO=15, then 32 cycles later HI=1, LO=4, with BUSY continuous.

Source files
------------

// File: rtl/mpa_mips_muldiv_if.sv
// Handshake and data bundle between the MIPS pipeline and the multiply/divide unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface mpa_mips_muldiv_if;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] RS;
  logic [31:0] RT;
  logic        HI_WE;
  logic        LO_WE;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output START, OP, RS, RT, HI_WE, LO_WE, WDATA,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, OP, RS, RT, HI_WE, LO_WE, WDATA,
    output BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/mpa_mips_muldiv.sv
// Iterative MIPS HI/LO unit: radix-2 shift-add multiply and restoring divide.
// Every operation takes a fixed 32 cycles; signs are stripped at START and restored on the final write.
//
// state | meaning
// IDLE  | waiting for START; MTHI/MTLO writes accepted
// RUN   | one multiply/divide iteration per edge, result written on the 32nd
module mpa_mips_muldiv (
  input  logic               CLK,
  input  logic               HW_RSTn,
  mpa_mips_muldiv_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic        is_div_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic [31:0] r_q;
  logic [31:0] q_q;
  logic [31:0] b_q;
  logic [5:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        op_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] r_nx;
  logic [31:0] q_nx;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  assign op_signed = ~bus.OP[0];
  assign abs_a     = (op_signed && bus.RS[31]) ? -bus.RS : bus.RS;
  assign abs_b     = (op_signed && bus.RT[31]) ? -bus.RT : bus.RT;

  // Multiply keeps {r_q,q_q} as the partial product shifting right; divide keeps
  // r_q as the partial remainder and shifts quotient bits into q_q from the right.
  always_comb begin
    mul_sum  = {1'b0, r_q} + (q_q[0] ? {1'b0, b_q} : 33'd0);
    div_sh   = {r_q, q_q[31]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh[31:0] - b_q;
    if (is_div_q) begin
      r_nx = div_ge ? div_diff : div_sh[31:0];
      q_nx = {q_q[30:0], div_ge};
    end else begin
      r_nx = mul_sum[32:1];
      q_nx = {mul_sum[0], q_q[31:1]};
    end
    prod_s = neg_q_q ? -{r_nx, q_nx} : {r_nx, q_nx};
    quot_s = neg_q_q ? -q_nx : q_nx;
    rem_s  = neg_r_q ? -r_nx : r_nx;
  end

  always_ff @(posedge CLK) begin
    if (!HW_RSTn) begin
      state    <= IDLE;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      r_q      <= 32'd0;
      q_q      <= 32'd0;
      b_q      <= 32'd0;
      cnt      <= 6'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.HI_WE) hi_q <= bus.WDATA;
          if (bus.LO_WE) lo_q <= bus.WDATA;
          if (bus.START) begin
            is_div_q <= bus.OP[1];
            neg_q_q  <= op_signed & (bus.RS[31] ^ bus.RT[31]);
            neg_r_q  <= op_signed & bus.RS[31];
            r_q      <= 32'd0;
            q_q      <= abs_a;
            b_q      <= abs_b;
            cnt      <= 6'd0;
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          r_q <= r_nx;
          q_q <= q_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            if (is_div_q) begin
              hi_q <= rem_s;
              lo_q <= quot_s;
            end else begin
              hi_q <= prod_s[63:32];
              lo_q <= prod_s[31:0];
            end
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mpa_mips_muldiv.sv
// Directed bench for mpa_mips_muldiv: hand-computed HI/LO results, latency,
// MTHI/MTLO handling, back-to-back issue and mid-run reset abort.
module tb_mpa_mips_muldiv;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic CLK = 1'b0;
  logic HW_RSTn = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   edge_cnt = 0;
  int   k_start = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  mpa_mips_muldiv_if bus ();
  mpa_mips_muldiv dut (.CLK(CLK), .HW_RSTn(HW_RSTn), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at or after a negedge; returns 1ns after the START edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.RS    = a;
    bus.RT    = b;
    @(posedge CLK);
    #1;
    k_start   = edge_cnt;
    bus.START = 1'b0;
    bus.RS    = $urandom;
    bus.RT    = $urandom;
  endtask

  task automatic wait_done(input string tag);
    do @(negedge CLK); while (!bus.DONE && (edge_cnt - k_start) < 40);
    chk({tag, " latency"}, 32'(edge_cnt - k_start), 32'd32);
    chk({tag, " busy low"}, {31'd0, bus.BUSY}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start_op(op, a, b);
    wait_done(tag);
    chk({tag, " HI"}, bus.HI, ehi);
    chk({tag, " LO"}, bus.LO, elo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    bus.START = 1'b0; bus.OP = 2'b00; bus.RS = 32'd0; bus.RT = 32'd0;
    bus.HI_WE = 1'b0; bus.LO_WE = 1'b0; bus.WDATA = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst BUSY", {31'd0, bus.BUSY}, 32'd0);
    chk("rst DONE", {31'd0, bus.DONE}, 32'd0);
    chk("rst HI", bus.HI, 32'd0);
    chk("rst LO", bus.LO, 32'd0);
    HW_RSTn = 1'b1;
    @(negedge CLK);

    run("multu max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult -3*7",  MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("mult min^2", MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("multu x16",  MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780);
    run("div -7/2",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div 7/-2",   DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("div ovf",    DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("divu 100/0", DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run("div -5/0",   DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001);
    run("div 7/0",    DIV,   32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);

    bus.LO_WE = 1'b1; bus.HI_WE = 1'b1; bus.WDATA = 32'h1234;
    @(posedge CLK); #1;
    bus.HI_WE = 1'b0; bus.WDATA = 32'h5678;
    @(posedge CLK); #1;
    bus.LO_WE = 1'b0;
    @(negedge CLK);
    chk("mthi", bus.HI, 32'h1234);
    chk("mtlo", bus.LO, 32'h5678);

    start_op(MULTU, 32'd3, 32'd5);
    repeat (3) @(negedge CLK);
    bus.LO_WE = 1'b1; bus.HI_WE = 1'b1; bus.WDATA = 32'hDEAD;
    @(posedge CLK); #1;
    bus.LO_WE = 1'b0; bus.HI_WE = 1'b0;
    @(negedge CLK);
    chk("mtlo in run", bus.LO, 32'h5678);
    chk("mthi in run", bus.HI, 32'h1234);
    wait_done("multu 3*5");
    chk("multu 3*5 HI", bus.HI, 32'd0);
    chk("multu 3*5 LO", bus.LO, 32'd15);
    start_op(DIVU, 32'd9, 32'd2);
    @(negedge CLK);
    chk("b2b busy", {31'd0, bus.BUSY}, 32'd1);
    wait_done("divu 9/2");
    chk("divu 9/2 HI", bus.HI, 32'd1);
    chk("divu 9/2 LO", bus.LO, 32'd4);

    bus.LO_WE = 1'b1; bus.WDATA = 32'h55;
    start_op(MULTU, 32'd6, 32'd7);
    bus.LO_WE = 1'b0;
    @(negedge CLK);
    chk("mtlo+start LO", bus.LO, 32'h55);
    wait_done("multu 6*7");
    chk("multu 6*7 HI", bus.HI, 32'd0);
    chk("multu 6*7 LO", bus.LO, 32'd42);

    start_op(DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge CLK);
    bus.START = 1'b1; bus.OP = MULTU; bus.RS = 32'd2; bus.RT = 32'd3;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    wait_done("divu 100/7");
    chk("divu 100/7 HI", bus.HI, 32'd2);
    chk("divu 100/7 LO", bus.LO, 32'd14);

    start_op(DIV, 32'hFFFF_FFF9, 32'd2);
    while (edge_cnt < k_start + 4) @(negedge CLK);
    bus.START = 1'b1; bus.OP = MULTU; bus.RS = 32'd11; bus.RT = 32'd13;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    while (edge_cnt < k_start + 9) @(negedge CLK);
    HW_RSTn = 1'b0;
    @(negedge CLK);
    HW_RSTn = 1'b1;
    chk("abort BUSY", {31'd0, bus.BUSY}, 32'd0);
    chk("abort HI", bus.HI, 32'd0);
    chk("abort LO", bus.LO, 32'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.DONE) seen_done = 1;
    end
    chk("abort no DONE", 32'(seen_done), 32'd0);
    chk("abort LO held", bus.LO, 32'd0);

    run("mult -1*-1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
